rgmii_idelay_tuner: RTL and testbench

- Drives the IDELAY load interface of gmii_to_rgmii (clk_div / idelay_ce / idelay_value_in) in place of the constant-zero placeholders.
- Sweeps all 32 RX IDELAY taps, qualifies each tap by checking received GMII frames, picks the centre of the widest passing window and loads it.
- Runs in the vgmii_rx_clk domain, so the caller drives clk_div from the same clock.
- Control and status connect to the marble_base ext_config / local-bus status registers.

---
 rtl/rgmii_idelay_tuner_pkg.sv | 32 +++
 rtl/rgmii_idelay_tuner_check.sv | 80 ++++++++
 rtl/rgmii_idelay_tuner.sv | 237 +++++++++++++++++++++++
 tb/tb_rgmii_idelay_tuner.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_idelay_tuner_pkg.sv
// Shared constants, FSM encoding and window helper for the RGMII RX IDELAY tuner.
package rgmii_idelay_tuner_pkg;

    localparam logic [7:0]  GMII_PREAMBLE = 8'h55;
    localparam logic [7:0]  GMII_SFD      = 8'hD5;
    localparam int unsigned TAP_W         = 5;
    localparam int unsigned NUM_TAPS      = 32;
    localparam int unsigned MAX_PREAMBLE  = 7;
    localparam int unsigned WIN_W         = 6;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_MEASURE,
        ST_NEXT,
        ST_PICK,
        ST_LOCKED,
        ST_FAIL,
        ST_MANUAL
    } state_t;

    // Centre of a window; even-length windows round towards the lower tap.
    function automatic logic [TAP_W-1:0] window_centre(input logic [TAP_W-1:0] start,
                                                       input logic [WIN_W-1:0] len);
        logic [WIN_W-1:0] half;
        half = (len - WIN_W'(1)) >> 1;
        return TAP_W'(WIN_W'(start) + half);
    endfunction

endpackage

// File: rtl/rgmii_idelay_tuner_check.sv
// gmii_preamble_check: qualifies each GMII RX frame by its preamble/SFD and rx_er,
// emitting a one-cycle frame_good or frame_bad pulse after dv falls.
module gmii_preamble_check
    import rgmii_idelay_tuner_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       abort,
    input  logic [7:0] rxd,
    input  logic       rx_dv,
    input  logic       rx_er,
    output logic       frame_good,
    output logic       frame_bad
);

    localparam int unsigned CNT_W = $clog2(MAX_PREAMBLE + 1);

    logic             dv_q;
    logic             open;
    logic [CNT_W-1:0] pre_cnt;
    logic             sfd_seen;
    logic             bad;

    logic [CNT_W-1:0] nxt_cnt;
    logic             nxt_sfd;
    logic             nxt_bad;

    // Per-byte update; a closed frame starts from a clean slate on the opening byte.
    always_comb begin
        nxt_cnt = open ? pre_cnt : '0;
        nxt_sfd = open & sfd_seen;
        nxt_bad = open & bad;
        if (rx_er) begin
            nxt_bad = 1'b1;
        end
        if (!nxt_sfd) begin
            if (rxd == GMII_PREAMBLE) begin
                if (nxt_cnt == CNT_W'(MAX_PREAMBLE)) begin
                    nxt_bad = 1'b1;
                end else begin
                    nxt_cnt = nxt_cnt + CNT_W'(1);
                end
            end else if (rxd == GMII_SFD && nxt_cnt != '0) begin
                nxt_sfd = 1'b1;
            end else begin
                nxt_bad = 1'b1;
            end
        end
    end

    // Abort wins over both opening and closing, so a frame spanning a tap load never reports.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dv_q       <= 1'b0;
            open       <= 1'b0;
            pre_cnt    <= '0;
            sfd_seen   <= 1'b0;
            bad        <= 1'b0;
            frame_good <= 1'b0;
            frame_bad  <= 1'b0;
        end else begin
            dv_q       <= rx_dv;
            frame_good <= 1'b0;
            frame_bad  <= 1'b0;
            if (abort) begin
                open <= 1'b0;
            end else if (rx_dv && (open || !dv_q)) begin
                open     <= 1'b1;
                pre_cnt  <= nxt_cnt;
                sfd_seen <= nxt_sfd;
                bad      <= nxt_bad;
            end else if (!rx_dv && open) begin
                open       <= 1'b0;
                frame_good <= sfd_seen & ~bad;
                frame_bad  <= ~(sfd_seen & ~bad);
            end
        end
    end

endmodule

// File: rtl/rgmii_idelay_tuner.sv
// RGMII RX IDELAY tuner: sweeps all taps, qualifies each with received frames and loads
// the centre of the widest passing window. IDELAY_MONITOR_EN adds bad-frame watch in LOCKED.
module rgmii_idelay_tuner
    import rgmii_idelay_tuner_pkg::*;
#(
    parameter int unsigned DWELL_FRAMES  = 16,
    parameter int unsigned TIMEOUT_CW    = 20,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned MIN_WINDOW    = 4,
    parameter int unsigned DEFAULT_TAP   = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             manual_en,
    input  logic [TAP_W-1:0] manual_tap,
    input  logic [7:0]       gmii_rxd,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    output logic             idelay_ce,
    output logic [TAP_W-1:0] idelay_value,
    output logic             busy,
    output logic             locked,
    output logic             fail,
    output logic [31:0]      pass_mask,
    output logic [WIN_W-1:0] win_len
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

    state_t                  state;
    logic [TAP_W-1:0]        tap;
    logic                    tap_pass;
    logic [SET_W-1:0]        settle_cnt;
    logic [7:0]              good_cnt;
    logic [TIMEOUT_CW-1:0]   timeout_cnt;
    logic [WIN_W-1:0]        pick_idx;
    logic [TAP_W-1:0]        run_start;
    logic [WIN_W-1:0]        run_len;
    logic [TAP_W-1:0]        best_start;
    logic [WIN_W-1:0]        best_len;
    logic                    chk_abort;
    logic                    frame_good;
    logic                    frame_bad;
    logic                    rescan_c;

    logic                    pick_bit_c;
    logic [TAP_W-1:0]        run_start_c;
    logic [WIN_W-1:0]        run_len_inc_c;

    gmii_preamble_check u_check (
        .clk        (clk),
        .rstn       (rstn),
        .abort      (chk_abort),
        .rxd        (gmii_rxd),
        .rx_dv      (gmii_rx_dv),
        .rx_er      (gmii_rx_er),
        .frame_good (frame_good),
        .frame_bad  (frame_bad)
    );

    // Window search helpers; index NUM_TAPS reads as a 0 so the last run is closed.
    always_comb begin
        pick_bit_c    = ~pick_idx[WIN_W-1] & pass_mask[pick_idx[TAP_W-1:0]];
        run_start_c   = (run_len == '0) ? pick_idx[TAP_W-1:0] : run_start;
        run_len_inc_c = run_len + WIN_W'(1);
    end

`ifdef IDELAY_MONITOR_EN
    logic [7:0] mon_bad;
    logic [7:0] mon_good;

    // Bad-frame watch while locked; every 256th good frame forgives the history.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mon_bad  <= '0;
            mon_good <= '0;
        end else if (state != ST_LOCKED) begin
            mon_bad  <= '0;
            mon_good <= '0;
        end else if (frame_bad) begin
            if (mon_bad != 8'hFF) begin
                mon_bad <= mon_bad + 8'd1;
            end
        end else if (frame_good) begin
            mon_good <= mon_good + 8'd1;
            if (mon_good == 8'hFF) begin
                mon_bad <= '0;
            end
        end
    end

    assign rescan_c = (state == ST_LOCKED) && frame_bad && (mon_bad >= 8'd3);
`else
    assign rescan_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_INIT;
            idelay_ce    <= 1'b0;
            idelay_value <= TAP_W'(DEFAULT_TAP);
            busy         <= 1'b0;
            locked       <= 1'b0;
            fail         <= 1'b0;
            pass_mask    <= '0;
            win_len      <= '0;
            tap          <= '0;
            tap_pass     <= 1'b0;
            settle_cnt   <= '0;
            good_cnt     <= '0;
            timeout_cnt  <= '0;
            pick_idx     <= '0;
            run_start    <= '0;
            run_len      <= '0;
            best_start   <= '0;
            best_len     <= '0;
            chk_abort    <= 1'b0;
        end else begin
            idelay_ce <= 1'b0;
            chk_abort <= 1'b0;
            if (manual_en && state != ST_MANUAL) begin
                state        <= ST_MANUAL;
                busy         <= 1'b0;
                locked       <= 1'b0;
                fail         <= 1'b0;
                idelay_ce    <= 1'b1;
                idelay_value <= manual_tap;
            end else begin
                case (state)
                    ST_INIT: begin
                        idelay_ce    <= 1'b1;
                        idelay_value <= TAP_W'(DEFAULT_TAP);
                        state        <= ST_IDLE;
                    end
                    ST_IDLE, ST_LOCKED, ST_FAIL: begin
                        if (start || rescan_c) begin
                            tap       <= '0;
                            pass_mask <= '0;
                            busy      <= 1'b1;
                            locked    <= 1'b0;
                            fail      <= 1'b0;
                            state     <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        idelay_value <= tap;
                        idelay_ce    <= 1'b1;
                        chk_abort    <= 1'b1;
                        settle_cnt   <= '0;
                        state        <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                            good_cnt    <= '0;
                            timeout_cnt <= '0;
                            state       <= ST_MEASURE;
                        end else begin
                            settle_cnt <= settle_cnt + SET_W'(1);
                        end
                    end
                    // A frame verdict takes priority over the timeout in the same cycle.
                    ST_MEASURE: begin
                        if (frame_bad) begin
                            tap_pass <= 1'b0;
                            state    <= ST_NEXT;
                        end else if (frame_good && good_cnt == 8'(DWELL_FRAMES - 1)) begin
                            tap_pass <= 1'b1;
                            state    <= ST_NEXT;
                        end else if (&timeout_cnt) begin
                            tap_pass <= 1'b0;
                            state    <= ST_NEXT;
                        end else begin
                            if (frame_good) begin
                                good_cnt <= good_cnt + 8'd1;
                            end
                            timeout_cnt <= timeout_cnt + TIMEOUT_CW'(1);
                        end
                    end
                    ST_NEXT: begin
                        pass_mask[tap] <= tap_pass;
                        if (tap == TAP_W'(NUM_TAPS - 1)) begin
                            pick_idx   <= '0;
                            run_start  <= '0;
                            run_len    <= '0;
                            best_start <= '0;
                            best_len   <= '0;
                            state      <= ST_PICK;
                        end else begin
                            tap   <= tap + TAP_W'(1);
                            state <= ST_LOAD;
                        end
                    end
                    // Strict '>' keeps the earliest of equally long runs.
                    ST_PICK: begin
                        if (pick_idx == WIN_W'(NUM_TAPS)) begin
                            win_len   <= best_len;
                            busy      <= 1'b0;
                            idelay_ce <= 1'b1;
                            if (best_len >= WIN_W'(MIN_WINDOW)) begin
                                idelay_value <= window_centre(best_start, best_len);
                                locked       <= 1'b1;
                                state        <= ST_LOCKED;
                            end else begin
                                idelay_value <= TAP_W'(DEFAULT_TAP);
                                fail         <= 1'b1;
                                state        <= ST_FAIL;
                            end
                        end else begin
                            if (pick_bit_c) begin
                                run_start <= run_start_c;
                                run_len   <= run_len_inc_c;
                                if (run_len_inc_c > best_len) begin
                                    best_len   <= run_len_inc_c;
                                    best_start <= run_start_c;
                                end
                            end else begin
                                run_len <= '0;
                            end
                            pick_idx <= pick_idx + WIN_W'(1);
                        end
                    end
                    ST_MANUAL: begin
                        if (!manual_en) begin
                            state <= ST_IDLE;
                        end else if (manual_tap != idelay_value) begin
                            idelay_ce    <= 1'b1;
                            idelay_value <= manual_tap;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgmii_idelay_tuner.sv
// Bench for rgmii_idelay_tuner: a tap-dependent frame source plus a scoreboard of expected
// IDELAY loads. With IDELAY_MONITOR_EN defined, also checks the automatic rescan.
module tb_rgmii_idelay_tuner;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        manual_en;
    logic [4:0]  manual_tap;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic        idelay_ce;
    logic [4:0]  idelay_value;
    logic        busy;
    logic        locked;
    logic        fail;
    logic [31:0] pass_mask;
    logic [5:0]  win_len;

    int         n_total = 0;
    int         n_bad   = 0;
    logic [4:0] exp_q[$];
    int         cur_tap    = 0;
    bit         traffic_on = 0;
    int         lo1 = 1, hi1 = 0, lo2 = 1, hi2 = 0;
    int         er_tap = -1;

    rgmii_idelay_tuner #(
        .DWELL_FRAMES  (2),
        .TIMEOUT_CW    (8),
        .SETTLE_CYCLES (16),
        .MIN_WINDOW    (4),
        .DEFAULT_TAP   (0)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .manual_en    (manual_en),
        .manual_tap   (manual_tap),
        .gmii_rxd     (gmii_rxd),
        .gmii_rx_dv   (gmii_rx_dv),
        .gmii_rx_er   (gmii_rx_er),
        .idelay_ce    (idelay_ce),
        .idelay_value (idelay_value),
        .busy         (busy),
        .locked       (locked),
        .fail         (fail),
        .pass_mask    (pass_mask),
        .win_len      (win_len)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit tap_good(input int t);
        return (t >= lo1 && t <= hi1) || (t >= lo2 && t <= hi2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Delay-line model and load scoreboard: every ce pulse must match the next expected tap.
    initial begin
        forever begin
            @(negedge clk);
            if (idelay_ce === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("ce_extra", 32'(idelay_ce), 32'd0);
                end else begin
                    check("ce_val", 32'(idelay_value), 32'(exp_q.pop_front()));
                end
                cur_tap = int'(idelay_value);
            end
        end
    end

    // Frame source: 7x preamble, SFD, 4 payload bytes, 2 idle; preamble corrupted on bad taps.
    initial begin
        gmii_rxd   = 8'h00;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        forever begin
            if (!traffic_on) begin
                tick();
                gmii_rx_dv = 1'b0;
                gmii_rx_er = 1'b0;
            end else begin
                for (int b = 0; b < 12; b++) begin
                    tick();
                    gmii_rx_dv = 1'b1;
                    if (b < 7)       gmii_rxd = tap_good(cur_tap) ? 8'h55 : 8'h54;
                    else if (b == 7) gmii_rxd = 8'hD5;
                    else             gmii_rxd = 8'(b * 17);
                    gmii_rx_er = (b == 9) && (cur_tap == er_tap);
                end
                repeat (2) begin
                    tick();
                    gmii_rx_dv = 1'b0;
                    gmii_rx_er = 1'b0;
                    gmii_rxd   = 8'h00;
                end
            end
        end
    end

    task automatic set_win(input int a1, input int b1, input int a2, input int b2);
        lo1 = a1; hi1 = b1; lo2 = a2; hi2 = b2;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(busy), 32'd0);
        repeat (2) tick();
        check({tag, "_sb"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_scan(input string tag, input logic [31:0] mask, input int len,
                            input int centre, input bit lock);
        for (int t = 0; t < 32; t++) exp_q.push_back(5'(t));
        exp_q.push_back(5'(centre));
        pulse_start();
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_idle(tag, 12000);
        check({tag, "_mask"}, pass_mask, mask);
        check({tag, "_len"}, 32'(win_len), 32'(len));
        check({tag, "_locked"}, 32'(locked), 32'(lock));
        check({tag, "_fail"}, 32'(fail), 32'(!lock));
        check({tag, "_val"}, 32'(idelay_value), 32'(centre));
    endtask

    initial begin
        int n;
        rstn       = 1'b0;
        start      = 1'b0;
        manual_en  = 1'b0;
        manual_tap = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ce", 32'(idelay_ce), 32'd0);
        check("rst_val", 32'(idelay_value), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_mask", pass_mask, 32'd0);
        check("rst_len", 32'(win_len), 32'd0);

        exp_q.push_back(5'd0);
        rstn = 1'b1;
        tick();
        check("init_ce", 32'(idelay_ce), 32'd1);
        check("init_val", 32'(idelay_value), 32'd0);
        tick();
        check("init_ce_once", 32'(idelay_ce), 32'd0);
        check("init_busy", 32'(busy), 32'd0);

        set_win(10, 19, 1, 0);
        traffic_on = 1'b1;
        repeat (20) tick();
        run_scan("scanA", 32'h000FFC00, 10, 14, 1'b1);

        set_win(2, 5, 20, 23);
        run_scan("scanB", 32'h00F0003C, 4, 3, 1'b1);

        traffic_on = 1'b0;
        run_scan("scanC", 32'h00000000, 0, 0, 1'b0);

        set_win(10, 19, 1, 0);
        er_tap     = 15;
        traffic_on = 1'b1;
        run_scan("scanD", 32'h000F7C00, 5, 12, 1'b1);

        er_tap = -1;
        for (int t = 0; t < 8; t++) exp_q.push_back(5'(t));
        pulse_start();
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        check("man_reach7", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(5'd22);
        manual_tap = 5'd22;
        manual_en  = 1'b1;
        repeat (4) tick();
        check("man_busy", 32'(busy), 32'd0);
        check("man_locked", 32'(locked), 32'd0);
        check("man_fail", 32'(fail), 32'd0);
        check("man_val22", 32'(idelay_value), 32'd22);
        check("man_sb22", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(5'd9);
        manual_tap = 5'd9;
        repeat (4) tick();
        check("man_val9", 32'(idelay_value), 32'd9);
        check("man_sb9", 32'(exp_q.size()), 32'd0);
        manual_en = 1'b0;
        repeat (30) tick();
        check("man_hold", 32'(idelay_value), 32'd9);
        check("man_idle_busy", 32'(busy), 32'd0);

        set_win(10, 19, 1, 0);
        run_scan("scanE", 32'h000FFC00, 10, 14, 1'b1);
`ifdef IDELAY_MONITOR_EN
        for (int t = 0; t < 32; t++) exp_q.push_back(5'(t));
        exp_q.push_back(5'd0);
        set_win(1, 0, 1, 0);
        n = 0;
        while (!busy && n < 400) begin
            tick();
            n++;
        end
        check("mon_rescan", 32'(busy), 32'd1);
        wait_idle("mon", 12000);
        check("mon_fail", 32'(fail), 32'd1);
        check("mon_mask", pass_mask, 32'd0);
`else
        set_win(1, 0, 1, 0);
        repeat (150) tick();
        check("static_locked", 32'(locked), 32'd1);
        check("static_busy", 32'(busy), 32'd0);
        check("static_sb", 32'(exp_q.size()), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
